// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: op codes, FSM states, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

   // Default sizing: 4-digit BCD operands, 14-bit binary (holds 9999), 8-digit result (holds 9999^2)
   localparam int DEF_IN_DIGITS  = 4;
   localparam int DEF_BIN_W      = 14;
   localparam int DEF_RES_DIGITS = 8;

   localparam logic [1:0] OP_MUL = 2'd0;
   localparam logic [1:0] OP_DIV = 2'd1;
   localparam logic [1:0] OP_ADD = 2'd2;
   localparam logic [1:0] OP_SUB = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      EXEC,
      B2BCD,
      DONE
   } state_t;

endpackage

// File: rtl/calc_bin2bcd.sv
// Iterative double-dabble converter: load a binary word, then one shift per step.
// Latency: IN_W steps after load; ready is high once every bit has been shifted in.
// Backpressure: none; step is ignored once ready, load restarts at any time.
module calc_bin2bcd #(
   parameter int IN_W   = 28,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic [IN_W-1:0]       din,
   output logic                  ready,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CW = $clog2(IN_W + 1);

   logic [IN_W-1:0]     bin_q;
   logic [4*DIGITS-1:0] bcd_q;
   logic [4*DIGITS-1:0] bcd_adj;
   logic [CW-1:0]       cnt_q;

   // Add 3 to every digit that is 5 or more, so the following shift carries into the next digit
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Load the binary word, then shift it MSB-first into the adjusted BCD register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         bin_q <= din;
         bcd_q <= '0;
         cnt_q <= CW'(IN_W);
      end else if (step && (cnt_q != '0)) begin
         {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
         cnt_q          <= cnt_q - 1'b1;
      end
   end

   assign ready = (cnt_q == '0);
   assign bcd   = bcd_q;

endmodule

// File: rtl/calc_sequencer.sv
// One calculator op on BCD operands: BCD->binary, add/sub/mul/div, binary->BCD. Macro CALC_REMAINDER_EN adds rem_bcd.
// Latency: start edge to done edge = 34 (add/sub), 47 (mul/div), 5 (bad digit or divide by zero).
// Backpressure: start is only accepted in IDLE; requests while busy (including DONE) are dropped.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int IN_DIGITS  = DEF_IN_DIGITS,
   parameter int BIN_W      = DEF_BIN_W,
   parameter int RES_DIGITS = DEF_RES_DIGITS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [4*IN_DIGITS-1:0]    a,
   input  logic [4*IN_DIGITS-1:0]    b,
   input  logic [1:0]                math,
`ifdef CALC_REMAINDER_EN
   output logic [4*IN_DIGITS-1:0]    rem_bcd,
`endif
   output logic                      busy,
   output logic                      done,
   output logic [4*RES_DIGITS-1:0]   result_bcd,
   output logic                      neg,
   output logic                      err
);

   localparam int CNT_W = $clog2(BIN_W + IN_DIGITS + 1);

   state_t state, state_nxt;

   // Shadow copies of the request; operands shift left one digit per CONV cycle
   logic [4*IN_DIGITS-1:0] a_sh, b_sh;
   logic [1:0]             op;
   logic [BIN_W-1:0]       a_bin, b_bin;
   logic                   bad;
   logic [CNT_W-1:0]       cnt;

   logic [2*BIN_W-1:0]     mul_p;
   logic [BIN_W-1:0]       div_q, div_r;
   logic                   neg_pend;

   logic [3:0]             a_dig, b_dig;
   logic [BIN_W-1:0]       a_conv, b_conv;

   logic [2*BIN_W-1:0]     mul_in, mul_nxt;
   logic [BIN_W:0]         mul_sum;
   logic [BIN_W-1:0]       q_in, r_in, q_nxt, r_nxt, r_sub;
   logic [BIN_W:0]         r_sh;
   logic                   r_ge;
   logic                   a_lt_b;
   logic [2*BIN_W-1:0]     exec_val;

   logic                   conv_load, conv_step, conv_ready, cvt_ready;
   logic                   fin_err, fin_ok;
   logic [4*RES_DIGITS-1:0] conv_bcd;

   assign a_dig  = a_sh[4*IN_DIGITS-1 -: 4];
   assign b_dig  = b_sh[4*IN_DIGITS-1 -: 4];
   assign a_conv = (a_bin << 3) + (a_bin << 1) + BIN_W'(a_dig);
   assign b_conv = (b_bin << 3) + (b_bin << 1) + BIN_W'(b_dig);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and step controls; operand validity is judged on the first EXEC cycle,
   // once both converted operands and the bad-digit flag are registered
   always_comb begin
      state_nxt = state;
      conv_load = 1'b0;
      conv_step = 1'b0;
      fin_err   = 1'b0;
      fin_ok    = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = CONV;
         CONV:  if (cnt == CNT_W'(IN_DIGITS - 1)) state_nxt = EXEC;
         EXEC: begin
            if ((cnt == '0) && (bad || ((op == OP_DIV) && (b_bin == '0)))) begin
               fin_err   = 1'b1;
               state_nxt = DONE;
            end else if ((op == OP_ADD) || (op == OP_SUB) || (cnt == CNT_W'(BIN_W - 1))) begin
               conv_load = 1'b1;
               state_nxt = B2BCD;
            end
         end
         B2BCD: begin
            if (cvt_ready) begin
               fin_ok    = 1'b1;
               state_nxt = DONE;
            end else begin
               conv_step = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One arithmetic iteration; the first EXEC cycle seeds from the converted operands,
   // and the final iteration feeds the converter directly so no cycle is spent re-registering
   always_comb begin
      mul_in  = (cnt == '0) ? {{BIN_W{1'b0}}, b_bin} : mul_p;
      mul_sum = {1'b0, mul_in[2*BIN_W-1:BIN_W]} +
                (mul_in[0] ? {1'b0, a_bin} : {(BIN_W+1){1'b0}});
      mul_nxt = {mul_sum, mul_in[BIN_W-1:1]};

      q_in    = (cnt == '0) ? a_bin : div_q;
      r_in    = (cnt == '0) ? '0 : div_r;
      r_sh    = {r_in, q_in[BIN_W-1]};
      r_ge    = (r_sh >= {1'b0, b_bin});
      r_sub   = r_sh[BIN_W-1:0] - b_bin;
      r_nxt   = r_ge ? r_sub : r_sh[BIN_W-1:0];
      q_nxt   = {q_in[BIN_W-2:0], r_ge};

      a_lt_b  = (a_bin < b_bin);

      exec_val = '0;
      case (op)
         OP_MUL:  exec_val = mul_nxt;
         OP_DIV:  exec_val = {{BIN_W{1'b0}}, q_nxt};
         OP_ADD:  exec_val = (2*BIN_W)'(a_bin) + (2*BIN_W)'(b_bin);
         default: exec_val = a_lt_b ? (2*BIN_W)'(b_bin - a_bin) : (2*BIN_W)'(a_bin - b_bin);
      endcase
   end

   // Request capture, digit-serial conversion and the multi-cycle arithmetic registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         op       <= '0;
         a_bin    <= '0;
         b_bin    <= '0;
         bad      <= 1'b0;
         cnt      <= '0;
         mul_p    <= '0;
         div_q    <= '0;
         div_r    <= '0;
         neg_pend <= 1'b0;
      end else begin
         if (state_nxt != state)                  cnt <= '0;
         else if ((state == CONV) || (state == EXEC)) cnt <= cnt + 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  op    <= math;
                  a_bin <= '0;
                  b_bin <= '0;
                  bad   <= 1'b0;
               end
            end
            CONV: begin
               a_bin <= a_conv;
               b_bin <= b_conv;
               a_sh  <= a_sh << 4;
               b_sh  <= b_sh << 4;
               bad   <= bad | (a_dig > 4'd9) | (b_dig > 4'd9);
            end
            EXEC: begin
               mul_p <= mul_nxt;
               div_q <= q_nxt;
               div_r <= r_nxt;
               if (conv_load) neg_pend <= (op == OP_SUB) && a_lt_b;
            end
            default: ;
         endcase
      end
   end

   calc_bin2bcd #(
      .IN_W   (2*BIN_W),
      .DIGITS (RES_DIGITS)
   ) u_res_cvt (
      .clk   (clk),
      .rst   (rst),
      .load  (conv_load),
      .step  (conv_step),
      .din   (exec_val),
      .ready (conv_ready),
      .bcd   (conv_bcd)
   );

`ifdef CALC_REMAINDER_EN
   logic                   rem_ready;
   logic [4*IN_DIGITS-1:0] rem_cvt_bcd;

   // The remainder is narrower, so it finishes inside the main conversion window
   calc_bin2bcd #(
      .IN_W   (BIN_W),
      .DIGITS (IN_DIGITS)
   ) u_rem_cvt (
      .clk   (clk),
      .rst   (rst),
      .load  (conv_load),
      .step  (conv_step),
      .din   (r_nxt),
      .ready (rem_ready),
      .bcd   (rem_cvt_bcd)
   );

   assign cvt_ready = conv_ready & rem_ready;

   // Remainder output: refreshed with every result, zero unless a divide completed
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         rem_bcd <= '0;
      else if (fin_err) rem_bcd <= '0;
      else if (fin_ok)  rem_bcd <= (op == OP_DIV) ? rem_cvt_bcd : '0;
   end
`else
   assign cvt_ready = conv_ready;
`endif

   // Result and flags change only on entry to DONE and hold until the next one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_bcd <= '0;
         neg        <= 1'b0;
         err        <= 1'b0;
      end else if (fin_err) begin
         result_bcd <= '0;
         neg        <= 1'b0;
         err        <= 1'b1;
      end else if (fin_ok) begin
         result_bcd <= conv_bcd;
         neg        <= neg_pend;
         err        <= 1'b0;
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: arithmetic model checked every cycle plus directed literal vectors.
// Latency: n/a.
// Backpressure: n/a.
module tb_calc_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [1:0]  math = '0;
   logic        busy, done, neg, err;
   logic [31:0] result_bcd;
`ifdef CALC_REMAINDER_EN
   logic [15:0] rem_bcd;
`endif

   calc_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .math       (math),
`ifdef CALC_REMAINDER_EN
      .rem_bcd    (rem_bcd),
`endif
      .busy       (busy),
      .done       (done),
      .result_bcd (result_bcd),
      .neg        (neg),
      .err        (err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int n_ops  = 0;
   int dut_dones = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- model: plain arithmetic on decimal values ----------------
   task automatic bcd2int(input logic [15:0] v, output int n, output bit bad);
      n   = 0;
      bad = 0;
      for (int i = 3; i >= 0; i--) begin
         logic [3:0] d;
         d = v[4*i +: 4];
         if (d > 4'd9) bad = 1;
         n = n * 10 + int'(d);
      end
   endtask

   function automatic logic [31:0] int2bcd(input longint v);
      logic [31:0] r;
      longint      t;
      r = '0;
      t = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   int          m_cd = 0;
   bit          m_done = 0;
   logic [31:0] m_res = '0, p_res = '0;
   logic        m_neg = 0, m_err = 0, p_neg = 0, p_err = 0;
   logic [15:0] m_rem = '0, p_rem = '0;

   task automatic predict();
      int va, vb;
      bit ba, bb;
      bcd2int(a, va, ba);
      bcd2int(b, vb, bb);
      p_res = '0; p_neg = 0; p_err = 0; p_rem = '0;
      if (ba || bb || (math == 2'd1 && vb == 0)) begin
         p_err = 1;
         m_cd  = 5;
      end else begin
         case (math)
            2'd0: begin p_res = int2bcd(longint'(va) * longint'(vb)); m_cd = 47; end
            2'd1: begin p_res = int2bcd(va / vb); p_rem = 16'(int2bcd(va % vb)); m_cd = 47; end
            2'd2: begin p_res = int2bcd(va + vb); m_cd = 34; end
            default: begin
               if (va < vb) begin p_res = int2bcd(vb - va); p_neg = 1; end
               else               p_res = int2bcd(va - vb);
               m_cd = 34;
            end
         endcase
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cd = 0; m_done = 0;
         m_res = '0; m_neg = 0; m_err = 0; m_rem = '0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_cd > 0) begin
         m_cd--;
         if (m_cd == 0) begin
            m_done = 1;
            m_res = p_res; m_neg = p_neg; m_err = p_err; m_rem = p_rem;
         end
      end else if (start) begin
         predict();
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      chk("busy", busy, (m_cd > 0 || m_done));
      chk("done", done, m_done);
      chk("result_bcd", result_bcd, m_res);
      chk("neg", neg, m_neg);
      chk("err", err, m_err);
`ifdef CALC_REMAINDER_EN
      chk("rem_bcd", rem_bcd, m_rem);
`endif
      if (done === 1'b1) dut_dones++;
   end

   // ---------------- directed vectors with literal expectations ----------------
   task automatic run_op(input logic [15:0] ai, input logic [15:0] bi, input logic [1:0] mi,
                         input logic [31:0] er, input logic en, input logic ee, input int el,
                         input logic [15:0] erem, input bit poke, input string tag);
      int n;
      bit got;
      a = ai; b = bi; math = mi; start = 1'b1;
      n_ops++;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      got = 0;
      while (!got && n < 200) begin
         @(negedge clk);
         n++;
         start = poke && (n == 10);
         if (poke && n == 10) a = 16'h0000;
         if (done === 1'b1) got = 1;
      end
      start = 1'b0;
      chk({tag, " latency"}, n, el);
      chk({tag, " result"}, result_bcd, er);
      chk({tag, " neg"}, neg, en);
      chk({tag, " err"}, err, ee);
`ifdef CALC_REMAINDER_EN
      chk({tag, " rem"}, rem_bcd, erem);
`else
      if (erem != erem) chk({tag, " rem"}, 0, 1);
`endif
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset result", result_bcd, 0);
      chk("reset flags", {neg, err}, 0);
      #2 rst = 1'b0;
      @(negedge clk);

      run_op(16'h1234, 16'h5678, 2'd0, 32'h07006652, 0, 0, 47, 16'h0000, 1, "mul1234");
      run_op(16'h9999, 16'h9999, 2'd0, 32'h99980001, 0, 0, 47, 16'h0000, 0, "mul9999");
      run_op(16'h9999, 16'h9999, 2'd2, 32'h00019998, 0, 0, 34, 16'h0000, 0, "add9999");
      run_op(16'h0100, 16'h0250, 2'd3, 32'h00000150, 1, 0, 34, 16'h0000, 0, "sub_neg");
      run_op(16'h0250, 16'h0100, 2'd3, 32'h00000150, 0, 0, 34, 16'h0000, 0, "sub_pos");
      run_op(16'h1000, 16'h0007, 2'd1, 32'h00000142, 0, 0, 47, 16'h0006, 0, "div7");
      run_op(16'h1000, 16'h0000, 2'd1, 32'h00000000, 0, 1, 5,  16'h0000, 0, "div0");
      run_op(16'h12A4, 16'h0001, 2'd2, 32'h00000000, 0, 1, 5,  16'h0000, 0, "bad_a");
      run_op(16'h0003, 16'h00F0, 2'd0, 32'h00000000, 0, 1, 5,  16'h0000, 0, "bad_b");
      run_op(16'h0042, 16'h0042, 2'd3, 32'h00000000, 0, 0, 34, 16'h0000, 0, "sub_eq");
      run_op(16'h9999, 16'h0001, 2'd1, 32'h00009999, 0, 0, 47, 16'h0000, 0, "div1");

      // Reset in the middle of a multiply: outputs clear at once, no done appears
      a = 16'h0012; b = 16'h0034; math = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst busy", busy, 0);
      chk("midrst done", done, 0);
      chk("midrst result", result_bcd, 0);
      chk("midrst flags", {neg, err}, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("no done after reset", dut_dones, n_ops);

      run_op(16'h0012, 16'h0034, 2'd0, 32'h00000408, 0, 0, 47, 16'h0000, 0, "mul_after_rst");
      repeat (3) @(negedge clk);
      chk("done count", dut_dones, n_ops);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
